// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router ingress: buffers one client packet, then streams
// header, payload and trailing parity byte back-to-back, honouring router busy stalls.
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  input  logic [1:0] req_dest,
  input  logic [5:0] req_len,
  output logic       req_ready,
  output logic       req_err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  input  logic       busy,
  output logic [7:0] tx_parity,
  output logic       tx_done
);

  // state   | meaning
  // IDLE    | waiting for a client request
  // LOAD    | collecting payload bytes into the buffer
  // HEADER  | driving {len,dest} to the router
  // PAYLOAD | driving buffered bytes to the router
  // PARITY  | driving XOR of header and payload, pkt_valid low
  // GAP     | forced idle cycles between packets
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0] state;
  logic [5:0] cnt;
  logic [5:0] len_q;
  logic [1:0] dest_q;
  logic [7:0] parity;
  logic [3:0] gap_cnt;
  logic [7:0] buffer [0:MAX_LEN-1];
  logic       req_legal;

  assign req_ready = (state == S_IDLE);
  assign pl_ready  = (state == S_LOAD);
  assign req_legal = (req_dest != 2'd3) && (req_len != 6'd0) && (int'(req_len) <= MAX_LEN);

  always_ff @(posedge clock)
    if (state == S_LOAD && pl_valid) buffer[cnt] <= pl_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      len_q     <= 6'd0;
      dest_q    <= 2'd0;
      parity    <= 8'h00;
      gap_cnt   <= 4'd0;
      pkt_valid <= 1'b0;
      data_in   <= 8'h00;
      req_err   <= 1'b0;
      tx_done   <= 1'b0;
      tx_parity <= 8'h00;
    end else begin
      req_err <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              dest_q <= req_dest;
              len_q  <= req_len;
              cnt    <= 6'd0;
              parity <= 8'h00;
              state  <= S_LOAD;
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (pl_valid) begin
            if (cnt == len_q - 6'd1) begin
              state     <= S_HEADER;
              pkt_valid <= 1'b1;
              data_in   <= {len_q, dest_q};
              parity    <= {len_q, dest_q};
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            cnt     <= 6'd0;
            data_in <= buffer[0];
            state   <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          // data_in holds the byte being taken, so fold it into parity on the take
          if (!busy) begin
            parity <= parity ^ data_in;
            if (cnt == len_q - 6'd1) begin
              pkt_valid <= 1'b0;
              data_in   <= parity ^ data_in;
              state     <= S_PARITY;
            end else begin
              cnt     <= cnt + 6'd1;
              data_in <= buffer[cnt + 6'd1];
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            tx_parity <= data_in;
            tx_done   <= 1'b1;
            data_in   <= 8'h00;
            if (GAP_CYCLES == 0) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= 4'(GAP_CYCLES - 1);
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
